// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM encoding,
// address-width derivation and port-slice helpers used by issue and writeback.
package rf_pkg;

  localparam int RF_XLEN_DFLT  = 32;
  localparam int RF_NREGS_DFLT = 32;
  localparam int RF_NRD_DFLT   = 2;
  localparam int RF_NWR_DFLT   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int rf_clog2(input int n);
    return $clog2(n);
  endfunction

  // Low bit of port p inside a flattened bus of w-bit lanes.
  function automatic int rf_lo(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/rf_mp_if.sv
// Register-file port bundle: write, read, reservation and soft-clear signals.
interface rf_mp_if
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DFLT,
  parameter int NREGS = RF_NREGS_DFLT,
  parameter int NRD   = RF_NRD_DFLT,
  parameter int NWR   = RF_NWR_DFLT
) ();
  localparam int AW = rf_clog2(NREGS);

  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rd_pend;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                clr;
  logic                busy;

  modport master (
    output we, waddr, wdata, raddr, rsv_en, rsv_addr, clr,
    input  rdata, rd_pend, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr, rsv_en, rsv_addr, clr,
    output rdata, rd_pend, busy
  );
endinterface

// File: rtl/rf_clear_seq.sv
// Soft-clear sequencer: walks idx from 1 to NREGS-1, one register per cycle,
// and raises busy for the whole walk.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DFLT,
  parameter int AW    = rf_clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_clr_stb,
  output logic [AW-1:0] o_idx
);
  clr_state_e    r_state, w_state_next;
  logic [AW-1:0] r_idx, w_idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (i_clr) begin
          w_state_next = CLEAR;
          w_idx_next   = AW'(1);
        end
      end
      CLEAR: begin
        // Exit on the last register so idx never wraps back onto x0.
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_next = IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + AW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_busy    = (r_state == CLEAR);
  assign o_clr_stb = (r_state == CLEAR);
  assign o_idx     = r_idx;
endmodule

// File: rtl/rf_mp.sv
// Multi-port integer register file with hardwired x0, optional same-cycle
// write bypass, per-register pending scoreboard and sequential soft clear.
module rf_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN_DFLT,
  parameter int NREGS  = RF_NREGS_DFLT,
  parameter int NRD    = RF_NRD_DFLT,
  parameter int NWR    = RF_NWR_DFLT,
  parameter int BYPASS = 1
) (
  input  logic    clk,
  input  logic    rst,
  rf_mp_if.slave  bus
);
  localparam int AW = rf_clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;

  logic             w_busy;
  logic             w_clr_stb;
  logic [AW-1:0]    w_clr_idx;
  logic [NREGS-1:0] w_wr_hit;
  logic [XLEN-1:0]  w_wr_data [NREGS];
  logic [NREGS-1:0] w_rsv_hit;

  rf_clear_seq #(.NREGS(NREGS), .AW(AW)) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst),
    .i_clr     (bus.clr),
    .o_busy    (w_busy),
    .o_clr_stb (w_clr_stb),
    .o_idx     (w_clr_idx)
  );

  // Ascending port order lets the highest-indexed writer win a collision.
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < NREGS; i++) w_wr_data[i] = '0;
    for (int p = 0; p < NWR; p++) begin
      if (bus.we[p] && !w_busy && (bus.waddr[rf_lo(p, AW) +: AW] != '0)) begin
        w_wr_hit[bus.waddr[rf_lo(p, AW) +: AW]]  = 1'b1;
        w_wr_data[bus.waddr[rf_lo(p, AW) +: AW]] = bus.wdata[rf_lo(p, XLEN) +: XLEN];
      end
    end
  end

  always_comb begin
    w_rsv_hit = '0;
    if (bus.rsv_en && !w_busy && (bus.rsv_addr != '0)) w_rsv_hit[bus.rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_clr_stb && (w_clr_idx == AW'(i))) begin
          r_regs[i] <= '0;
          r_pend[i] <= 1'b0;
        end else begin
          if (w_wr_hit[i]) r_regs[i] <= w_wr_data[i];
          // A reservation names a new producer, so it beats a retiring write.
          if (w_rsv_hit[i])     r_pend[i] <= 1'b1;
          else if (w_wr_hit[i]) r_pend[i] <= 1'b0;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_byp;
      assign w_ra  = bus.raddr[gi*AW +: AW];
      assign w_byp = (BYPASS != 0) && w_wr_hit[w_ra];
      assign bus.rdata[gi*XLEN +: XLEN] = (w_ra == '0) ? '0 :
                                          w_byp ? w_wr_data[w_ra] : r_regs[w_ra];
      assign bus.rd_pend[gi] = r_pend[w_ra] && !w_byp;
    end
  endgenerate

  assign bus.busy = w_busy;
endmodule
